hp_add_scheduler: RTL and testbench
===================================

// Module: hp_add_scheduler
// PURPOSE
//   Round-robin scheduler that shares one combinational half-precision adder (hp_adder) among NREQ requesters.
//   Each requester uses a valid/ready request and a tagged valid/ready response.
//   The block grants one requester, latches its operands and drives them onto the shared adder.
//   It waits SETTLE cycles for the adder to settle, then registers sum, exceptions and requester ID.
//   It sits between the requesting units and the single hp_adder instance at the same hierarchy level.
// PARAMETERS
//   NREQ    4  number of requesters (2..8)
//   ID_W    2  width of rsp_id; must equal clog2(NREQ)
//   SETTLE  1  cycles operands are held on add_a/add_b before capture (>=1)
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   NREQ     request valid, one bit per requester
//   req_ready  out  NREQ     one-hot grant; handshake = req_valid[i] & req_ready[i]
//   req_a      in   16*NREQ  operand A; requester i on bits [16i+15:16i]
//   req_b      in   16*NREQ  operand B, same packing as req_a
//   rsp_valid  out  1        response valid
//   rsp_ready  in   1        response accepted by consumer
//   rsp_id     out  ID_W     index of the requester this response belongs to
//   rsp_sum    out  16       registered adder sum
//   rsp_exc    out  2        registered adder exceptions (00 ok, 01 inf/ovf, 11 NaN)
//   busy       out  1        high in EXEC or RESP
//   add_a      out  16       operand A to the shared adder (registered)
//   add_b      out  16       operand B to the shared adder (registered)
//   add_sum    in   16       sum from the shared adder (combinational)
//   add_exc    in   2        exceptions from the shared adder
// BEHAVIOUR
//   Reset (async, rst_n=0) clears these to 0: rsp_valid, rsp_id, rsp_sum, rsp_exc, add_a, add_b, busy and cnt.
//     State goes to IDLE; last_grant goes to NREQ-1, so requester 0 has highest priority first.
//     req_ready is 0 during reset.
//   FSM has three states: IDLE, EXEC and RESP.
//   IDLE
//     Winner = first i with req_valid[i], scanning last_grant+1, +2, ... mod NREQ.
//     req_ready[winner]=1 combinationally in the same cycle; all other req_ready bits are 0.
//     On the handshake: latch req_a/req_b of the winner into add_a/add_b, set last_grant=winner, set cnt=SETTLE-1, go to EXEC.
//     No valid requests: stay in IDLE; req_ready=0.
//   EXEC
//     req_ready=0.
//     cnt!=0: decrement cnt.
//     cnt==0: capture add_sum->rsp_sum, add_exc->rsp_exc, winner->rsp_id; set rsp_valid=1; go to RESP.
//   RESP
//     rsp_valid=1; rsp_sum, rsp_exc and rsp_id are held stable.
//     rsp_ready=1: clear rsp_valid and go to IDLE. The next grant happens in the following cycle, not the same cycle.
//   Latency: handshake in cycle T -> rsp_valid high in cycle T+SETTLE+1.
//     Minimum issue interval = SETTLE+2 cycles.
//   add_a/add_b hold their last operands after completion. The adder output is sampled only in the EXEC capture cycle.
//   Requesters must hold req_a/req_b stable while req_valid is high.
//     Dropping req_valid before a grant is legal; arbitration uses current-cycle req_valid only.
//   rsp_ready held low stalls indefinitely in RESP; no request is granted while stalled.
//   Reset asserted in EXEC or RESP aborts the operation. No response is produced; priority restarts at requester 0.
//   No arithmetic is done in this block; sum, exception and sign handling all come from the adder.
//   No requester can starve: after a grant it has lowest priority until all others have been offered.
// TESTING
//   1 rst_n=0 with random inputs -> all outputs 0, req_ready=0; after release, state is IDLE and busy=0.
//   2 req_valid=0001, A=3C00, B=3C00, SETTLE=1 -> req_ready=0001 in cycle T; rsp_valid in cycle T+2 with rsp_sum=4000, rsp_exc=00, rsp_id=0.
//   3 req_valid=1111 held with rsp_ready=1 -> grants in order 0,1,2,3,0, each 3 cycles apart; each rsp_id matches its grant.
//     Requester 1 A=5246, B=53B4 -> rsp_sum=56FD.
//   4 NaN and infinity passthrough:
//     A=7E00, B=3C00 -> rsp_sum=7E00, rsp_exc=11.
//     A=7C00, B=3C00 -> rsp_sum=7C00, rsp_exc=01.
//     A=4000, B=C000 -> rsp_sum=0000, rsp_exc=00.
//   5 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, req_ready=0 although req_valid=1111, busy=1.
//     Then rsp_ready=1 -> IDLE, and the next grant goes to the next index.
//   6 rst_n pulsed low in EXEC with last_grant=2 -> no rsp_valid afterwards; with req_valid=1111 the next grant is requester 0.

Source files
------------

// File: rtl/hp_add_scheduler.sv
// Round-robin scheduler sharing one combinational half-precision adder among NREQ requesters.
// Grants one requester, holds its operands on the adder for SETTLE cycles, then returns a tagged response.
module hp_add_scheduler #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_sum,
  output logic [1:0]           rsp_exc,
  output logic                 busy,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  input  logic [15:0]          add_sum,
  input  logic [1:0]           add_exc
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic             grant_fire;
  logic             capture;
  logic             rsp_done;

  // Rotating-priority scan starting just after the previous winner.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Grant is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == S_IDLE) && found) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant_fire = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          grant_fire = 1'b1;
          state_nxt  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every datapath flop is reset so an aborted operation leaves no stale response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NREQ - 1);
      cnt        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_sum    <= '0;
      rsp_exc    <= '0;
      busy       <= 1'b0;
    end else begin
      if (grant_fire) begin
        add_a      <= req_a[int'(winner)*16 +: 16];
        add_b      <= req_b[int'(winner)*16 +: 16];
        last_grant <= winner;
        cnt        <= CNT_W'(SETTLE - 1);
        busy       <= 1'b1;
      end else if ((state == S_EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      // The adder output is sampled only here; add_a/add_b keep their values afterwards.
      if (capture) begin
        rsp_sum   <= add_sum;
        rsp_exc   <= add_exc;
        rsp_id    <= last_grant;
        rsp_valid <= 1'b1;
      end

      if (rsp_done) begin
        rsp_valid <= 1'b0;
        busy      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hp_add_scheduler.sv
// Directed bench for hp_add_scheduler: a lookup-table adder stands in for hp_adder,
// and expected responses queue up at each grant and are popped when the response appears.
module tb_hp_add_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a, req_b;
  logic               rsp_valid, rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_sum;
  logic [1:0]         rsp_exc;
  logic               busy;
  logic [15:0]        add_a, add_b, add_sum;
  logic [1:0]         add_exc;

  typedef struct {
    int          id;
    logic [15:0] sum;
    logic [1:0]  exc;
  } rsp_t;

  rsp_t        sb[$];
  logic [15:0] op_a[NREQ], op_b[NREQ], exp_sum[NREQ];
  logic [1:0]  exp_exc[NREQ];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hp_add_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_exc(rsp_exc), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_exc(add_exc)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = op_a[i];
      req_b[16*i +: 16] = op_b[i];
    end
  end

  // Stand-in for the shared adder: known operand pairs only, anything else is flagged garbage.
  always_comb begin
    case ({add_a, add_b})
      32'h3C00_3C00: {add_sum, add_exc} = {16'h4000, 2'b00};
      32'h5246_53B4: {add_sum, add_exc} = {16'h56FD, 2'b00};
      32'h7E00_3C00: {add_sum, add_exc} = {16'h7E00, 2'b11};
      32'h7C00_3C00: {add_sum, add_exc} = {16'h7C00, 2'b01};
      32'h4000_C000: {add_sum, add_exc} = {16'h0000, 2'b00};
      default:       {add_sum, add_exc} = {16'hFFFF, 2'b10};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE: drive the request mask and expect a one-hot grant.
  task automatic grant(input logic [NREQ-1:0] vmask, input int exp_id, input bit push);
    logic [NREQ-1:0] onehot;
    onehot    = 4'b0001 << exp_id;
    req_valid = vmask;
    #1;
    check("req_ready_grant", 32'(req_ready), 32'(onehot));
    if (push) sb.push_back('{exp_id, exp_sum[exp_id], exp_exc[exp_id]});
  endtask

  // Bounded wait for rsp_valid, then pop the scoreboard and compare.
  task automatic collect();
    rsp_t e;
    int   n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    check("rsp_latency", n, 0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check("rsp_id", 32'(rsp_id), e.id);
      check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      check("rsp_exc", 32'(rsp_exc), 32'(e.exc));
    end
    check("req_ready_resp", 32'(req_ready), 32'd0);
  endtask

  // One full transaction from a grant at negedge G to the response at G+2.
  task automatic run_one(input logic [NREQ-1:0] vmask, input int exp_id);
    grant(vmask, exp_id, 1'b1);
    @(negedge clk);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    collect();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Test 1: reset with random inputs.
    rst_n     = 1'b0;
    rsp_ready = 1'($urandom);
    req_valid = 4'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 16'($urandom);
      op_b[i] = 16'($urandom);
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_exc", 32'(rsp_exc), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    op_a[0] = 16'h3C00; op_b[0] = 16'h3C00; exp_sum[0] = 16'h4000; exp_exc[0] = 2'b00;
    op_a[1] = 16'h5246; op_b[1] = 16'h53B4; exp_sum[1] = 16'h56FD; exp_exc[1] = 2'b00;
    op_a[2] = 16'h7E00; op_b[2] = 16'h3C00; exp_sum[2] = 16'h7E00; exp_exc[2] = 2'b11;
    op_a[3] = 16'h7C00; op_b[3] = 16'h3C00; exp_sum[3] = 16'h7C00; exp_exc[3] = 2'b01;
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd0);

    // Test 2: single request from requester 0.
    run_one(4'b0001, 0);
    req_valid = '0;
    @(negedge clk);
    check("hold_add_a", 32'(add_a), 32'h3C00);
    check("hold_add_b", 32'(add_b), 32'h3C00);
    check("done_busy", 32'(busy), 32'd0);
    check("done_rsp_valid", 32'(rsp_valid), 32'd0);

    // Test 3 and most of 4: all requesters held, fresh priority from reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_one(4'b1111, i % NREQ);
      if (i == 4) req_valid = '0;
      @(negedge clk);
    end

    // Test 4: +2 plus -2 gives +0.
    op_a[0] = 16'h4000; op_b[0] = 16'hC000; exp_sum[0] = 16'h0000; exp_exc[0] = 2'b00;
    run_one(4'b0001, 0);
    req_valid = '0;
    @(negedge clk);

    // Test 5: consumer stalls in RESP; last grant was 0, so requester 1 wins.
    rsp_ready = 1'b0;
    grant(4'b1111, 1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    collect();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_sum", 32'(rsp_sum), 32'h56FD);
      check("stall_rsp_id", 32'(rsp_id), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    grant(4'b1111, 2, 1'b0);

    // Test 6: reset in EXEC with last_grant=2 aborts and restarts priority at 0.
    @(negedge clk);
    check("abort_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_one(4'b1111, 0);
    req_valid = '0;
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
